// File: rtl/shift_result_checker.sv
// shift_result_checker
// Response checker for the barrel shifter. It takes one vector per handshake,
// recomputes the expected rotation one bit position per clock, compares it with
// the shifter's observed output, pulses a result and keeps saturating pass/fail
// tallies so a board can self-test without a simulator.

module shift_result_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vecValid,
  output logic             vecReady,
  input  logic [WIDTH-1:0] num,
  input  logic [AMT_W-1:0] amt,
  input  logic             lr,
  input  logic [WIDTH-1:0] shiftedNum,
  input  logic             clearCounts,
  output logic             resultValid,
  output logic             pass,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] passCount,
  output logic [CNT_W-1:0] failCount
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMPARE
  } stateType;

  stateType         state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] observed;
  logic [AMT_W-1:0] remaining;
  logic             dirRight;

  // Handshake, bit-serial rotation and result registration; vecReady comes up on
  // the first edge out of reset and is dropped while a vector is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      work        <= '0;
      observed    <= '0;
      remaining   <= '0;
      dirRight    <= 1'b0;
      vecReady    <= 1'b0;
      resultValid <= 1'b0;
      pass        <= 1'b0;
      expected    <= '0;
    end else begin
      resultValid <= 1'b0;
      case (state)
        IDLE: begin
          if (!vecReady) begin
            vecReady <= 1'b1;
          end else if (vecValid) begin
            work      <= num;
            observed  <= shiftedNum;
            remaining <= amt;
            dirRight  <= lr;
            vecReady  <= 1'b0;
            state     <= (amt != '0) ? SHIFT : COMPARE;
          end
        end
        SHIFT: begin
          if (dirRight) begin
            work <= {work[0], work[WIDTH-1:1]};
          end else begin
            work <= {work[WIDTH-2:0], work[WIDTH-1]};
          end
          remaining <= remaining - AMT_W'(1);
          if (remaining == AMT_W'(1)) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          expected    <= work;
          pass        <= (work == observed);
          resultValid <= 1'b1;
          vecReady    <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state    <= IDLE;
          vecReady <= 1'b0;
        end
      endcase
    end
  end

  // Saturating tallies; a clear on the compare edge takes priority over counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      passCount <= '0;
      failCount <= '0;
    end else if (clearCounts) begin
      passCount <= '0;
      failCount <= '0;
    end else if (state == COMPARE) begin
      if (work == observed) begin
        if (passCount != '1) begin
          passCount <= passCount + CNT_W'(1);
        end
      end else begin
        if (failCount != '1) begin
          failCount <= failCount + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_result_checker.sv
// Testbench for shift_result_checker: directed vectors followed by randomized
// vectors, all checked against a rotation/tally model built from plain arithmetic.
// A second instance with 4-bit tallies exposes saturation in a short run.

module tb_shift_result_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       vecValid;
  logic       clearCounts;
  logic       lr;
  logic [7:0] num;
  logic [7:0] shiftedNum;
  logic [2:0] amt;

  logic        vecReady;
  logic        resultValid;
  logic        pass;
  logic [7:0]  expected;
  logic [15:0] passCount;
  logic [15:0] failCount;

  logic        satReady;
  logic        satValid;
  logic        satPass;
  logic [7:0]  satExpected;
  logic [3:0]  satPassCount;
  logic [3:0]  satFailCount;

  int total = 0;
  int bad = 0;

  int modelPass = 0;
  int modelFail = 0;
  int modelSatPass = 0;
  int modelSatFail = 0;
  logic [7:0] lastExp = 8'h00;
  logic       lastPass = 1'b0;

  shift_result_checker dut (
    .clk(clk),
    .reset(reset),
    .vecValid(vecValid),
    .vecReady(vecReady),
    .num(num),
    .amt(amt),
    .lr(lr),
    .shiftedNum(shiftedNum),
    .clearCounts(clearCounts),
    .resultValid(resultValid),
    .pass(pass),
    .expected(expected),
    .passCount(passCount),
    .failCount(failCount)
  );

  shift_result_checker #(.WIDTH(8), .CNT_W(4)) dutSat (
    .clk(clk),
    .reset(reset),
    .vecValid(vecValid),
    .vecReady(satReady),
    .num(num),
    .amt(amt),
    .lr(lr),
    .shiftedNum(shiftedNum),
    .clearCounts(clearCounts),
    .resultValid(satValid),
    .pass(satPass),
    .expected(satExpected),
    .passCount(satPassCount),
    .failCount(satFailCount)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] required);
    total++;
    if (observed !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, required);
    end
  endtask

  // Circular rotation of an 8-bit value using a doubled word
  function automatic logic [7:0] rotRef(input logic [7:0] n, input int a, input logic l);
    logic [15:0] both;
    both = {n, n};
    if (l) begin
      both = both >> a;
      return both[7:0];
    end
    both = both << a;
    return both[15:8];
  endfunction

  task automatic modelCompare(input bit ok, input bit clr);
    if (clr) begin
      modelPass = 0;
      modelFail = 0;
      modelSatPass = 0;
      modelSatFail = 0;
    end else if (ok) begin
      if (modelPass < 65535) modelPass++;
      if (modelSatPass < 15) modelSatPass++;
    end else begin
      if (modelFail < 65535) modelFail++;
      if (modelSatFail < 15) modelSatFail++;
    end
  endtask

  task automatic modelReset();
    modelPass = 0;
    modelFail = 0;
    modelSatPass = 0;
    modelSatFail = 0;
    lastExp = 8'h00;
    lastPass = 1'b0;
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, ".passCount"}, passCount, modelPass);
    checkOutput({tag, ".failCount"}, failCount, modelFail);
    checkOutput({tag, ".satPassCount"}, satPassCount, modelSatPass);
    checkOutput({tag, ".satFailCount"}, satFailCount, modelSatFail);
  endtask

  // Send one vector starting at a negedge, follow it to its result pulse and check it.
  task automatic applyStimulus(input logic [7:0] n, input int a, input logic l, input logic [7:0] s,
                               input bit clrAtCompare, input bit keepValid);
    logic [7:0] refVal;
    bit ok;
    bit seen;
    bit spurious;
    int waitCnt;
    int lat;
    refVal = rotRef(n, a, l);
    ok = (refVal == s);
    spurious = 1'b0;
    waitCnt = 0;
    while (!vecReady && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("readyTimeout", 0, 1);
    num = n;
    amt = 3'(a);
    lr = l;
    shiftedNum = s;
    vecValid = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !keepValid) vecValid = 1'b0;
      if (resultValid || satValid) begin
        seen = 1'b1;
      end else begin
        if (expected !== lastExp || pass !== lastPass) spurious = 1'b1;
        if (lat == a + 1 && clrAtCompare) clearCounts = 1'b1;
      end
    end
    clearCounts = 1'b0;
    checkOutput("latency", seen ? lat : 99, a + 2);
    checkOutput("heldBeforeResult", spurious, 0);
    modelCompare(ok, clrAtCompare);
    lastExp = refVal;
    lastPass = ok;
    checkOutput("pass", pass, ok);
    checkOutput("expected", expected, refVal);
    checkOutput("satPass", satPass, ok);
    checkOutput("satExpected", satExpected, refVal);
    checkOutput("readyAfterResult", vecReady, 1);
    checkCounts("result");
  endtask

  initial begin
    bit prevKeep;
    reset = 1'b1;
    vecValid = 1'b0;
    clearCounts = 1'b0;
    lr = 1'b0;
    num = 8'h00;
    amt = 3'd0;
    shiftedNum = 8'h00;

    // Reset state and vecReady rise after release
    repeat (3) @(negedge clk);
    checkOutput("reset.vecReady", vecReady, 0);
    checkOutput("reset.resultValid", resultValid, 0);
    checkOutput("reset.expected", expected, 0);
    checkCounts("reset");
    reset = 1'b0;
    #1;
    checkOutput("release.vecReadyLow", vecReady, 0);
    @(negedge clk);
    checkOutput("release.vecReadyHigh", vecReady, 1);

    // Directed vectors
    applyStimulus(8'b00000111, 7, 1'b0, 8'b10000011, 1'b0, 1'b0);
    applyStimulus(8'b11100010, 6, 1'b0, 8'b10111000, 1'b0, 1'b0);
    applyStimulus(8'b01011001, 1, 1'b1, 8'b10101100, 1'b0, 1'b0);
    applyStimulus(8'b00000111, 3, 1'b1, 8'b11100001, 1'b0, 1'b0);
    applyStimulus(8'b00000001, 0, 1'b0, 8'b00000001, 1'b0, 1'b1);
    applyStimulus(8'b10010110, 0, 1'b1, 8'b10010110, 1'b0, 1'b1);
    applyStimulus(8'b10010110, 2, 1'b1, 8'b10100101, 1'b0, 1'b0);
    applyStimulus(8'b11000000, 5, 1'b1, 8'b00000110, 1'b1, 1'b0);
    applyStimulus(8'b00110000, 4, 1'b0, 8'b00000011, 1'b0, 1'b0);
    applyStimulus(8'b00110000, 4, 1'b0, 8'b00000000, 1'b0, 1'b0);

    // Reset in the middle of a rotation discards the vector
    num = 8'h5A;
    amt = 3'd7;
    lr = 1'b0;
    shiftedNum = 8'h2D;
    vecValid = 1'b1;
    @(negedge clk);
    vecValid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("midReset.vecReady", vecReady, 0);
    checkOutput("midReset.resultValid", resultValid, 0);
    checkOutput("midReset.pass", pass, 0);
    checkOutput("midReset.expected", expected, 0);
    checkCounts("midReset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midRelease.vecReadyLow", vecReady, 0);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (resultValid || satValid) pulses++;
      end
      checkOutput("midRelease.noResult", pulses, 0);
    end
    checkOutput("midRelease.vecReadyHigh", vecReady, 1);

    // Randomized vectors, enough to saturate the narrow tallies
    prevKeep = 1'b0;
    for (int k = 0; k < 160; k++) begin
      logic [7:0] n;
      logic [7:0] s;
      int a;
      logic l;
      bit clr;
      bit keep;
      n = 8'($urandom);
      a = $urandom_range(0, 7);
      l = 1'($urandom);
      s = rotRef(n, a, l);
      if ($urandom_range(0, 9) < 3) s = s ^ 8'($urandom_range(1, 255));
      clr = ($urandom_range(0, 29) == 0);
      keep = ($urandom_range(0, 9) < 3);
      if (!prevKeep) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) @(negedge clk);
      end
      applyStimulus(n, a, l, s, clr, keep);
      prevKeep = keep;
    end
    vecValid = 1'b0;

    // Standalone clear while idle
    @(negedge clk);
    clearCounts = 1'b1;
    @(negedge clk);
    clearCounts = 1'b0;
    modelCompare(1'b1, 1'b1);
    checkCounts("idleClear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
